led_scan_sequencer: RTL and testbench
=====================================

Name: led_scan_sequencer

Overview:
Top-level scan controller for the AL422-fed HUB-style LED panel. It rewinds and reads the AL422 frame FIFO, paces the 2-byte-per-pixel receive datapath, and drives panel latch, output-enable and row address. It also generates the PWM plane value fed to the RGB555 colour comparators. It sits between the AL422 read port and the pixel receive/compare stage, and is the only block that sequences panel timing.

Parameters:
COLS, 64, pixels shifted per row (2 FIFO bytes each)
ROWS, 16, scan rows per plane; row_addr width = clog2(ROWS)
PWM_BITS, 5, PWM plane count = 2^PWM_BITS
BLANK_CYCLES, 4, oe_n-high cycles before latch (>=1)
PIPE_LAT, 2, cycles from FIFO read of 2nd pixel byte to pix_valid

Ports:
in_clk  input  1  system clock; all logic on rising edge
in_nrst  input  1  asynchronous active-low reset
enable  input  1  run request
fifo_re_n  output  1  AL422 read enable, active low
fifo_rrst_n  output  1  AL422 read-pointer reset, active low
pwm_value  output  8  current PWM plane; upper 8-PWM_BITS bits always 0
pix_valid  output  1  one-cycle pulse: pixel at comparator output is valid; register it and clock it into the panel
latch  output  1  panel latch strobe, active high
oe_n  output  1  panel output enable, active low
row_addr  output  clog2(ROWS)  panel row select
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse at end of the last plane

Behaviour:
- Reset (async, in_nrst=0): state=IDLE; fifo_re_n=1, fifo_rrst_n=1, oe_n=1, latch=0, pix_valid=0, frame_done=0, busy=0, row_addr=0, pwm_value=0; all counters and the PIPE_LAT shift register cleared. Assertion mid-operation aborts immediately. No partial-row recovery: the next run starts with RRST.
- Registered outputs only; no combinational path from inputs to outputs.
- States: IDLE, RRST, SHIFT, BLANK, LATCH.
- IDLE: oe_n=1. enable=1 -> RRST on the next cycle.
- RRST: fifo_rrst_n=0 for exactly 2 cycles, fifo_re_n=1 -> SHIFT. row counter=0.
- SHIFT: fifo_re_n=0 for exactly 2*COLS consecutive cycles. The byte counter b runs 0..2*COLS-1. When b is odd, a 1 is pushed into the PIPE_LAT-deep delay line; its output is pix_valid. This gives exactly COLS pix_valid pulses per row. The last pulse may land in BLANK/LATCH. After the final byte -> BLANK.
- BLANK: oe_n=1, fifo_re_n=1 for BLANK_CYCLES cycles. row_addr <= current row on the first BLANK cycle. -> LATCH.
- LATCH: latch=1 for 1 cycle, oe_n=1.
  - If row < ROWS-1: row++, then -> SHIFT; oe_n=0 from the first SHIFT cycle.
  - If row = ROWS-1: end of plane. pwm_value is incremented modulo 2^PWM_BITS.
    - On wrap to 0: frame_done=1 for that one cycle.
    - Then -> RRST if enable=1, else -> IDLE.
- Across plane boundaries, oe_n stays 0 during RRST; the last latched row keeps displaying.
- oe_n is held 1 from reset/IDLE exit until the first LATCH of a run completes.
- pwm_value is constant for a whole plane and changes only in the LATCH-to-next-state transition.
- enable is sampled only in IDLE and at plane end. Deasserting mid-plane completes the plane, then IDLE with oe_n=1.
- Timing (defaults):
  - Row = 2*COLS + BLANK_CYCLES + 1 = 133 cycles.
  - Plane = 2 + ROWS*133 = 2130 cycles.
  - Frame = 32*2130 = 68160 cycles.
- Invariants: latch and fifo_re_n=0 never coincide; oe_n=1 whenever latch=1; fifo_rrst_n=0 never coincides with fifo_re_n=0.

Test Plan:
- Reset, then enable=1 at cycle 0: fifo_rrst_n low for cycles 1-2; fifo_re_n low for cycles 3-130 (128 cycles); oe_n=1 throughout until the first latch, at cycle 135.
- One full row: count fifo_re_n-low cycles = 128 and pix_valid pulses = 64. The first pix_valid occurs PIPE_LAT=2 cycles after the 2nd read cycle. row_addr=0 before latch, and row 1 shifts next.
- Full plane: 16 latch pulses with row_addr 0..15, 2130 cycles between successive fifo_rrst_n falling edges, pwm_value 0->1 after the 16th latch.
- Full frame: pwm_value runs 0..31 and wraps to 0; a single frame_done pulse at cycle 68160 after start; next RRST follows immediately.
- Drop enable at row 5 of plane 3: plane 3 completes all 16 rows, then busy=0, oe_n=1, pwm_value=4, no further fifo_re_n activity.
- Assert in_nrst low mid-SHIFT: all outputs return to reset values asynchronously. On release with enable=1, the sequence restarts with a 2-cycle RRST and row_addr=0, pwm_value=0.

Source files
------------

// File: rtl/led_scan_sequencer.sv
// Scan sequencer for an AL422-fed HUB LED panel. It rewinds and reads the frame FIFO, paces
// pixel delivery, drives latch/oe_n/row select and steps the PWM plane counter.
module led_scan_sequencer #(
    parameter int unsigned COLS         = 64,
    parameter int unsigned ROWS         = 16,
    parameter int unsigned PWM_BITS     = 5,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned PIPE_LAT     = 2
) (
    input  logic                    in_clk,
    input  logic                    in_nrst,
    input  logic                    enable,
    output logic                    fifo_re_n,
    output logic                    fifo_rrst_n,
    output logic [7:0]              pwm_value,
    output logic                    pix_valid,
    output logic                    latch,
    output logic                    oe_n,
    output logic [$clog2(ROWS)-1:0] row_addr,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int unsigned RowW   = $clog2(ROWS);
    localparam int unsigned Bytes  = 2 * COLS;
    localparam int unsigned CntTop = (Bytes > BLANK_CYCLES) ? Bytes : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntTop + 1);

    typedef enum logic [2:0] {StIdle, StRrst, StShift, StBlank, StLatch} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RowW-1:0]     row_q, row_d;
    logic [RowW-1:0]     row_addr_q, row_addr_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                lit_q, lit_d;
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic                re_n_q, re_n_d;
    logic                rrst_n_q, rrst_n_d;
    logic                latch_q, latch_d;
    logic                oe_n_q, oe_n_d;
    logic                busy_q, busy_d;
    logic                fdone_q, fdone_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        row_addr_d = row_addr_q;
        pwm_d      = pwm_q;
        lit_d      = lit_q;
        fdone_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                lit_d = 1'b0;
                cnt_d = '0;
                if (enable) begin
                    state_d = StRrst;
                end
            end
            StRrst: begin
                row_d = '0;
                if (cnt_q == CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == CntW'(Bytes - 1)) begin
                    cnt_d      = '0;
                    row_addr_d = row_q;
                    state_d    = StBlank;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBlank: begin
                if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StLatch;
                    // Pulse lands on the latch of the last row of the last plane.
                    fdone_d = (row_q == RowW'(ROWS - 1)) && (&pwm_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                lit_d = 1'b1;
                if (row_q != RowW'(ROWS - 1)) begin
                    row_d   = row_q + 1'b1;
                    state_d = StShift;
                end else begin
                    pwm_d   = pwm_q + 1'b1;
                    state_d = enable ? StRrst : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        rrst_n_d = (state_d != StRrst);
        re_n_d   = (state_d != StShift);
        latch_d  = (state_d == StLatch);
        busy_d   = (state_d != StIdle);
        oe_n_d   = !(lit_d && ((state_d == StShift) || (state_d == StRrst)));
    end

    // Every odd byte completes a pixel; it emerges PIPE_LAT cycles later.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = (state_q == StShift) && cnt_q[0];
        for (int i = 1; i < int'(PIPE_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            row_q      <= '0;
            row_addr_q <= '0;
            pwm_q      <= '0;
            lit_q      <= 1'b0;
            pipe_q     <= '0;
            re_n_q     <= 1'b1;
            rrst_n_q   <= 1'b1;
            latch_q    <= 1'b0;
            oe_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            row_addr_q <= row_addr_d;
            pwm_q      <= pwm_d;
            lit_q      <= lit_d;
            pipe_q     <= pipe_d;
            re_n_q     <= re_n_d;
            rrst_n_q   <= rrst_n_d;
            latch_q    <= latch_d;
            oe_n_q     <= oe_n_d;
            busy_q     <= busy_d;
            fdone_q    <= fdone_d;
        end
    end

    assign fifo_re_n   = re_n_q;
    assign fifo_rrst_n = rrst_n_q;
    assign pwm_value   = 8'(pwm_q);
    assign pix_valid   = pipe_q[PIPE_LAT-1];
    assign latch       = latch_q;
    assign oe_n        = oe_n_q;
    assign row_addr    = row_addr_q;
    assign busy        = busy_q;
    assign frame_done  = fdone_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer: an arithmetic schedule model predicts every output cycle, and a
// negedge monitor compares the DUT against the queued predictions.
module tb_led_scan_sequencer;
    localparam int COLS     = 64;
    localparam int ROWS     = 16;
    localparam int PWM_BITS = 5;
    localparam int BLANK    = 4;
    localparam int PIPE_LAT = 2;
    localparam int R        = 2 * COLS + BLANK + 1;
    localparam int P        = 2 + ROWS * R;
    localparam int NPL      = 1 << PWM_BITS;

    typedef struct packed {
        logic       rrst_n;
        logic       re_n;
        logic [7:0] pwm;
        logic       pix;
        logic       latch;
        logic       oe_n;
        logic [3:0] row;
        logic       busy;
        logic       fdone;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    localparam obs_t RstObs = '{rrst_n: 1'b1, re_n: 1'b1, pwm: 8'd0, pix: 1'b0, latch: 1'b0,
                                oe_n: 1'b1, row: 4'd0, busy: 1'b0, fdone: 1'b0};

    logic       in_clk = 1'b0;
    logic       in_nrst = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_re_n, fifo_rrst_n, pix_valid, latch, oe_n, busy, frame_done;
    logic [7:0] pwm_value;
    logic [3:0] row_addr;

    led_scan_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .PWM_BITS(PWM_BITS), .BLANK_CYCLES(BLANK), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .in_clk(in_clk), .in_nrst(in_nrst), .enable(enable), .fifo_re_n(fifo_re_n),
        .fifo_rrst_n(fifo_rrst_n), .pwm_value(pwm_value), .pix_valid(pix_valid), .latch(latch),
        .oe_n(oe_n), .row_addr(row_addr), .busy(busy), .frame_done(frame_done)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0, errs = 0;

    // Model state: a run is a contiguous stretch of planes starting at run_start.
    bit run_act = 1'b0;
    int run_start = 0, pwm_base = 0, last_row = 0;

    int k0 = -1;
    int latch_cnt = 0, fd_cnt = 0, first_latch = -1, first_fd = -1, pix_row0 = 0, re_row0 = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
            if (errs >= 40) begin
                $display("Result: errors=%0d of %0d checks", errs, checks);
                $finish;
            end
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.rrst_n = fifo_rrst_n;
        o.re_n   = fifo_re_n;
        o.pwm    = pwm_value;
        o.pix    = pix_valid;
        o.latch  = latch;
        o.oe_n   = oe_n;
        o.row    = row_addr;
        o.busy   = busy;
        o.fdone  = frame_done;
        return o;
    endfunction

    function automatic obs_t model_at(input int k);
        obs_t o;
        int t, pl, off, u, r, c, prev;
        o        = RstObs;
        o.pwm    = 8'(pwm_base);
        o.row    = 4'(last_row);
        if (!run_act) return o;
        t      = k - run_start;
        pl     = t / P;
        off    = t % P;
        o.busy = 1'b1;
        o.pwm  = 8'((pwm_base + pl) % NPL);
        prev   = (pl == 0) ? last_row : ROWS - 1;
        if (off < 2) begin
            o.rrst_n = 1'b0;
            o.row    = 4'(prev);
            o.oe_n   = (pl == 0);
        end else begin
            u = off - 2;
            r = u / R;
            c = u % R;
            if (c < 2 * COLS) begin
                o.re_n = 1'b0;
                o.row  = 4'((r == 0) ? prev : r - 1);
                o.oe_n = (pl == 0 && r == 0);
            end else if (c < 2 * COLS + BLANK) begin
                o.row = 4'(r);
            end else begin
                o.latch = 1'b1;
                o.row   = 4'(r);
                o.fdone = (r == ROWS - 1) && (o.pwm == 8'(NPL - 1));
            end
            if (c >= PIPE_LAT && (c - PIPE_LAT) < 2 * COLS && ((c - PIPE_LAT) % 2) == 1)
                o.pix = 1'b1;
        end
        return o;
    endfunction

    // Drive enable for the current cycle and queue the prediction for the next one.
    task automatic step(input logic en);
        int k, t;
        k      = cyc;
        enable = en;
        if (!run_act) begin
            if (en) begin
                run_act   = 1'b1;
                run_start = k + 1;
            end
        end else begin
            t = k - run_start;
            if (t % P == P - 1 && !en) begin
                run_act  = 1'b0;
                pwm_base = (pwm_base + t / P + 1) % NPL;
                last_row = ROWS - 1;
            end
        end
        exp_q.push_back('{cyc: k + 1, o: model_at(k + 1)});
        @(posedge in_clk);
        #1;
    endtask

    always @(negedge in_clk) begin
        if (in_nrst) begin
            if (latch) begin
                latch_cnt++;
                if (first_latch < 0) first_latch = cyc;
            end
            if (frame_done) begin
                fd_cnt++;
                if (first_fd < 0) first_fd = cyc;
            end
            if (k0 >= 0 && cyc - k0 <= 135) begin
                if (pix_valid) pix_row0++;
                if (!fifo_re_n) re_row0++;
            end
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            chk("outputs", int'(observe()), int'(mon_e.o));
        end
    end

    int t_drop;

    initial begin
        repeat (3) @(posedge in_clk);
        #1;
        chk("reset_outputs", int'(observe()), int'(RstObs));
        @(negedge in_clk);
        in_nrst = 1'b1;
        @(posedge in_clk);
        #1;
        k0 = cyc;

        // Full frame plus the start of the next one.
        while (cyc < k0 + NPL * P + 5) step(1'b1);
        chk("first_latch_cycle", first_latch - k0, 135);
        chk("frame_done_cycle", first_fd - k0, 68160);
        chk("frame_done_count", fd_cnt, 1);
        chk("latches_per_frame", latch_cnt, 512);
        chk("row0_pix_count", pix_row0, 64);
        chk("row0_read_count", re_row0, 128);

        // Drop enable somewhere in row 5 of the plane with pwm_value 3.
        t_drop = 35 * P + 2 + 5 * R + int'($urandom_range(R - 1, 0));
        while (cyc - run_start < t_drop) step(1'b1);
        while (run_act) step(1'b0);
        repeat (20) step(1'b0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_pwm", int'(pwm_value), 4);
        chk("idle_oe_n", int'(oe_n), 1);
        chk("idle_re_n", int'(fifo_re_n), 1);

        // Restart, then abort with reset in the middle of the first row's shift.
        repeat ($urandom_range(20, 3)) step(1'b0);
        step(1'b1);
        repeat ($urandom_range(120, 3)) step(1'b1);
        chk("pre_reset_re_n", int'(fifo_re_n), 0);
        #1;
        in_nrst = 1'b0;
        exp_q.delete();
        run_act  = 1'b0;
        pwm_base = 0;
        last_row = 0;
        #1;
        chk("async_reset_outputs", int'(observe()), int'(RstObs));
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        in_nrst = 1'b1;
        repeat (300) step(1'b1);
        chk("restart_pwm", int'(pwm_value), 0);
        chk("restart_busy", int'(busy), 1);

        // Random enable: only the IDLE and plane-end samples may matter.
        repeat (5000) step($urandom_range(3, 0) != 0);
        repeat (3) step(1'b0);
        @(negedge in_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
